// File: rtl/mux_pkg.sv
// Shared encodings and width helper for the round-robin N:1 multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel index width; at least one bit even for very small channel counts.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr (wrapping) for the first
// requester and moves ptr past the winner when the caller strobes advance.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int SELW = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant_oh,
  output logic [SELW-1:0]     grant_idx,
  output logic                grant_exists
);

  logic [SELW-1:0] ptr_q, ptr_d;
  int              idx;

  always_comb begin
    grant_oh     = '0;
    grant_idx    = '0;
    grant_exists = 1'b0;
    idx          = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_exists && req[idx]) begin
        grant_exists  = 1'b1;
        grant_idx     = SELW'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N:1 channel multiplexer with fixed-select or round-robin arbitration,
// feeding a one-entry registered output stage.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  localparam int SELW = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           select,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Handshake: a beat moves when valid & ready are both high on a rising edge;
  // valid never waits on ready, and ready may depend on valid but not on data.

  logic                load_en, xfer_in, advance;
  logic                rr_exists, fix_exists, grant_exists;
  logic [CHANNELS-1:0] rr_oh, fix_oh, grant_oh;
  logic [SELW-1:0]     rr_idx, grant_idx;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_chan_q, out_chan_d;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (in_valid),
    .advance      (advance),
    .grant_oh     (rr_oh),
    .grant_idx    (rr_idx),
    .grant_exists (rr_exists)
  );

  // Out-of-range select values match no channel and therefore grant nothing.
  always_comb begin
    fix_oh     = '0;
    fix_exists = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (select == SELW'(i) && in_valid[i]) begin
        fix_oh[i]  = 1'b1;
        fix_exists = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh     = fix_oh;
    grant_idx    = select;
    grant_exists = fix_exists;
    if (mode == MODE_RR) begin
      grant_oh     = rr_oh;
      grant_idx    = rr_idx;
      grant_exists = rr_exists;
    end
  end

  assign load_en  = ~out_valid_q | out_ready;
  assign xfer_in  = grant_exists & load_en;
  assign advance  = xfer_in & (mode == MODE_RR);
  assign in_ready = grant_oh & {CHANNELS{load_en & rst_n}};

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_chan_d  = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr against a behavioural channel/queue model.
module tb_mux_nto1_rr;

  localparam int W    = 4;
  localparam int CH   = 4;
  localparam int SELW = 2;

  logic              clk;
  logic              rst_n;
  logic [CH*W-1:0]   in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic              mode;
  logic [SELW-1:0]   select;
  logic [W-1:0]      out_data;
  logic [SELW-1:0]   out_chan;
  logic              out_valid;
  logic              out_ready;

  logic [W-1:0]      ch_data [CH];

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit                m_valid;
  logic [W-1:0]      m_data;
  int                m_chan;
  int                m_ptr;
  logic [SELW+W-1:0] exp_q[$];

  mux_nto1_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .select    (select),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = ch_data[i];
  end

  // ---------------- reference model ----------------
  function automatic int model_grant();
    if (!rst_n) return -1;
    if (mode == 1'b0) begin
      if (int'(select) < CH && in_valid[select]) return int'(select);
      return -1;
    end
    for (int k = 0; k < CH; k++)
      if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
    return -1;
  endfunction

  function automatic logic [CH-1:0] model_ready();
    int g;
    g = model_grant();
    if (g >= 0 && (!m_valid || out_ready)) return CH'(1) << g;
    return '0;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
    exp_q.delete();
  endfunction

  function automatic void model_clock();
    int g;
    bit load, out_xfer;
    g        = model_grant();
    load     = !m_valid || out_ready;
    out_xfer = m_valid && out_ready;
    if (out_xfer && exp_q.size() > 0) void'(exp_q.pop_front());
    if (load && g >= 0) begin
      m_valid = 1'b1;
      m_data  = ch_data[g];
      m_chan  = g;
      exp_q.push_back({SELW'(g), ch_data[g]});
      if (mode) m_ptr = (g + 1) % CH;
    end else if (out_xfer) begin
      m_valid = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic drive(input logic m, input logic [SELW-1:0] s, input logic [CH-1:0] v,
                       input logic ordy);
    mode      = m;
    select    = s;
    in_valid  = v;
    out_ready = ordy;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, 2'd0, 4'b1111, 1'b1);
    for (int i = 0; i < CH; i++) ch_data[i] = W'(i + 5);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== '0 || out_chan !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%0d exp=0/0", out_data, out_chan);
    end
    checks++;
    if (in_ready !== '0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 4'b0000, 1'b1);
  endtask

  task automatic test_fixed();
    ch_data[2] = 4'hA;
    drive(1'b0, 2'd2, 4'b0100, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hA || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL fixed_out got=v%b d%h c%0d exp=v1 dA c2", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_rr_sequence();
    for (int i = 0; i < CH; i++) ch_data[i] = W'(i);
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_chan) != k % CH || out_data !== W'(k % CH)) begin
        errors++;
        $display("FAIL rr_seq[%0d] got=v%b c%0d d%h exp=v1 c%0d d%h", k, out_valid, out_chan,
                 out_data, k % CH, k % CH);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_seq [3];
    exp_seq = '{3, 0, 3};
    drive(1'b1, 2'd0, 4'b0001, 1'b1);
    tick();
    checks++;
    if (out_chan !== 2'd0 || m_ptr != 1) begin
      errors++; $display("FAIL wrap_setup got=c%0d exp=c0", out_chan);
    end
    in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", k, in_ready, model_ready());
      end
      tick();
      checks++;
      if (int'(out_chan) != exp_seq[k] || out_valid !== 1'b1) begin
        errors++; $display("FAIL wrap[%0d] got=c%0d exp=c%0d", k, out_chan, exp_seq[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]    held_d;
    logic [SELW-1:0] held_c;
    for (int i = 0; i < CH; i++) ch_data[i] = W'(4'h8 + i);
    drive(1'b1, 2'd0, 4'b1111, 1'b0);
    held_d = out_data;
    held_c = out_chan;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=0000", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_chan !== held_c) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=v%b d%h c%0d exp=v1 d%h c%0d", k, out_valid, out_data,
                 out_chan, held_d, held_c);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (in_ready !== model_ready() || in_ready === 4'b0000) begin
        errors++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", k, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_chan) != m_chan || out_data !== m_data) begin
        errors++;
        $display("FAIL b2b_out[%0d] got=v%b c%0d d%h exp=v1 c%0d d%h", k, out_valid, out_chan,
                 out_data, m_chan, m_data);
      end
    end
  endtask

  task automatic test_no_grant_and_reset();
    drive(1'b1, 2'd0, 4'b0000, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain got=v%b exp=v0", out_valid); end
    drive(1'b0, 2'd1, 4'b1000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL nogrant_ready[%0d] got=%b exp=0000", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL nogrant_valid[%0d] got=%b exp=0", k, out_valid); end
    end
    drive(1'b0, 2'd3, 4'b1000, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd3) begin
      errors++; $display("FAIL preload got=v%b c%0d exp=v1 c3", out_valid, out_chan);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      errors++; $display("FAIL midreset got=v%b r%b exp=v0 r0000", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 4'b0110, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL post_reset_ready got=%b exp=0010", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== ch_data[1]) begin
      errors++;
      $display("FAIL post_reset_grant got=v%b c%0d d%h exp=v1 c1 d%h", out_valid, out_chan,
               out_data, ch_data[1]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CH; i++) ch_data[i] = W'($urandom_range(0, (1 << W) - 1));
      drive(1'($urandom_range(0, 3) != 0), SELW'($urandom_range(0, CH - 1)),
            CH'($urandom_range(0, (1 << CH) - 1)), 1'($urandom_range(0, 3) != 0));
      #1;
      checks++;
      if (in_ready !== model_ready() || !$onehot0(in_ready)) begin
        errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", k, in_ready, model_ready());
      end
      if (m_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_sb_empty[%0d] got=v%b exp=queued entry", k, out_valid);
        end else if ({out_chan, out_data} !== exp_q[0]) begin
          errors++; $display("FAIL rand_sb[%0d] got=%h exp=%h", k, {out_chan, out_data}, exp_q[0]);
        end
      end
      tick();
      checks++;
      if (out_valid !== m_valid || (m_valid && (int'(out_chan) != m_chan || out_data !== m_data))) begin
        errors++;
        $display("FAIL rand_out[%0d] got=v%b c%0d d%h exp=v%b c%0d d%h", k, out_valid, out_chan,
                 out_data, m_valid, m_chan, m_data);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'b0000, 1'b0);
    for (int i = 0; i < CH; i++) ch_data[i] = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_fixed();
    test_rr_sequence();
    test_wrap();
    test_back_to_back();
    test_no_grant_and_reset();
    apply_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_nto1_rr.md
MUX_NTO1_RR -- requirements
Module: mux_nto1_rr

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel (legal values 1 to 64).
REQ-002 Parameter CHANNELS, default 4, number of input channels (legal values 2 to 16).
REQ-003 Localparam SELW = max(1, clog2(CHANNELS)), the width of the channel index.
REQ-004 clk  input  1  single clock; all registers update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel data-valid.
REQ-008 in_ready  output  CHANNELS  per-channel accept; at most one bit high.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 select  input  SELW  channel index used when mode = 0.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SELW  index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_chan hold a transfer.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 A transfer on channel i occurs in a cycle where in_valid[i] & in_ready[i] = 1; a transfer on the output occurs where out_valid & out_ready = 1.
REQ-016 The output stage is a one-entry register; load_en = ~out_valid | out_ready.
REQ-017 Mode 0: grant = select when in_valid[select] = 1, else no grant; a select value >= CHANNELS grants nothing.
REQ-018 Mode 1: grant = first channel with in_valid set, searching upward from ptr and wrapping modulo CHANNELS.
REQ-019 in_ready[i] = (grant == i) & grant_exists & load_en; in_ready is combinational and free of combinational paths from in_data.
REQ-020 On an input transfer from channel g: out_data <= channel g data, out_chan <= g, out_valid <= 1; latency from input transfer to out_valid is 1 cycle.
REQ-021 When out_valid & out_ready = 1 with no input transfer in the same cycle, out_valid <= 0 and out_data/out_chan hold their values.
REQ-022 A simultaneous output transfer and input transfer replaces the entry with no bubble, sustaining 1 transfer per cycle.
REQ-023 While out_valid = 1 and out_ready = 0, out_data, out_chan and out_valid are stable and all in_ready bits are 0.
REQ-024 ptr (SELW bits, range 0..CHANNELS-1) updates only on a mode-1 input transfer: ptr <= (g+1) mod CHANNELS, wrapping CHANNELS-1 to 0.
REQ-025 ptr holds its value in mode 0; a mode change takes effect in the same cycle with no flush of the output register.
REQ-026 No input in_valid set: no grant, and the output register behaves per REQ-021/023.
REQ-027 Round-robin fairness: with all CHANNELS valid and out_ready = 1, each channel is granted exactly once in every CHANNELS consecutive transfers.

Reset
REQ-028 rst_n low, asynchronously: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0; in_ready reads all-zero while rst_n is low.
REQ-029 Reset asserted mid-transfer discards the held entry; the first grant after release in mode 1 searches from channel 0.

Structure
REQ-030 Package mux_pkg holds the mode encodings MODE_FIXED = 0 and MODE_RR = 1 and the SELW computation function.
REQ-031 One sub-module, rr_arbiter (parameter CHANNELS), holds ptr and produces the grant one-hot, grant index and grant_exists from a request vector and an advance strobe.
REQ-032 The datapath mux is a parametrised index select with no per-bit hand instantiation.

Verification
REQ-033 Reset with defaults, then drive mode 0, select = 2, in_valid = 4'b0100, data2 = 4'hA, out_ready = 1 -> next cycle out_valid = 1, out_data = A, out_chan = 2.
REQ-034 Mode 1, all valid, data_i = i, out_ready = 1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
REQ-035 Mode 1, in_valid = 4'b1001, ptr = 1 -> grant is channel 3, then channel 0 (wrap), then channel 3.
REQ-036 Hold out_ready = 0 for 5 cycles with out_valid = 1 -> out_data stable, in_ready = 0; on release -> back-to-back transfers with no idle cycle.
REQ-037 Mode 0, select = 1, only in_valid[3] set -> in_ready = 0 and out_valid stays 0; then assert rst_n low mid-stream -> out_valid drops immediately, first mode-1 grant after release is the lowest valid channel >= 0.
